// File: rtl/delay_us_seq.sv
// -----------------------------------------------------------------------------
// delay_us_seq
//   Microsecond delay sequencer. An accepted start loads a microsecond count.
//   Each 1 us tick from the upstream timer counts it down. A single-cycle done
//   pulse is produced when the count expires. An abort or a reset cancels a
//   running delay without producing a done pulse.
//
// Ports
//   i_clk_36MHz  in   system clock, all logic on its rising edge
//   i_reset      in   synchronous active-low reset (0 = reset)
//   i_tick_1us   in   one-cycle strobe once per microsecond
//   i_start      in   request to begin a delay (accepted in IDLE/DONE)
//   i_delay_us   in   requested delay in us, sampled on an accepted start
//   i_abort      in   cancels a running delay; blocks a same-cycle start
//   o_busy       out  high while a delay is running (state RUN)
//   o_done       out  one-cycle completion pulse (state DONE)
//   o_remaining  out  microseconds still to elapse
// -----------------------------------------------------------------------------
module delay_us_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk_36MHz,
   input  logic             i_reset,
   input  logic             i_tick_1us,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_delay_us,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_remaining
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q = S_IDLE;
   state_t           state_d;
   logic [WIDTH-1:0] remaining_q = '0;
   logic [WIDTH-1:0] remaining_d;
   logic             busy_q = 1'b0;
   logic             busy_d;
   logic             done_q = 1'b0;
   logic             done_d;

   // State register: all outputs come straight from flops.
   always_ff @(posedge i_clk_36MHz) begin
      if (!i_reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and count logic. Abort outranks start and tick. A start
   // load outranks a coincident tick, so that tick is never counted.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            // DONE always lasts exactly one cycle.
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
            if (i_start && !i_abort) begin
               remaining_d = i_delay_us;
               state_d     = (i_delay_us == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (i_abort) begin
               state_d     = S_IDLE;
               remaining_d = '0;
            end else if (i_tick_1us && (remaining_q != '0)) begin
               remaining_d = remaining_q - WIDTH'(1);
               if (remaining_q == WIDTH'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // Output decode from the next state, so that busy/done are registered
   // alongside the state and match it every cycle.
   always_comb begin
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_remaining = remaining_q;

`ifdef FORMAL
   cover_done : cover property (@(posedge i_clk_36MHz) o_done);
   cover_max_load : cover property (@(posedge i_clk_36MHz)
      o_busy && (o_remaining == {WIDTH{1'b1}}));
   assert_busy_done_excl : assert property (@(posedge i_clk_36MHz)
      !(o_busy && o_done));
   assert_done_zero : assert property (@(posedge i_clk_36MHz)
      o_done |-> (o_remaining == '0));
`endif

endmodule

// File: tb/tb_delay_us_seq.sv
// -----------------------------------------------------------------------------
// tb_delay_us_seq
//   Self-checking bench for delay_us_seq. Stimulus pushes the cycle number at
//   which each o_done pulse is due into a queue. A monitor pops an entry on
//   every o_done and compares it. The stimulus also checks busy/remaining at
//   chosen points.
// -----------------------------------------------------------------------------
module tb_delay_us_seq;

   localparam int unsigned WIDTH = 16;

   logic             i_clk_36MHz = 1'b0;
   logic             i_reset     = 1'b0;
   logic             i_tick_1us  = 1'b0;
   logic             i_start     = 1'b0;
   logic [WIDTH-1:0] i_delay_us  = '0;
   logic             i_abort     = 1'b0;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_remaining;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cycle = 0;
   int unsigned exp_q[$];
   int unsigned e;

   delay_us_seq #(.WIDTH(WIDTH)) dut (
      .i_clk_36MHz (i_clk_36MHz),
      .i_reset     (i_reset),
      .i_tick_1us  (i_tick_1us),
      .i_start     (i_start),
      .i_delay_us  (i_delay_us),
      .i_abort     (i_abort),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_remaining (o_remaining)
   );

   always #14 i_clk_36MHz = ~i_clk_36MHz;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: every o_done must match the next queued completion cycle.
   initial begin
      int unsigned want;
      forever begin
         @(posedge i_clk_36MHz);
         cycle++;
         #1;
         if (o_done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cycle);
            end else begin
               want = exp_q.pop_front();
               chk("done_cycle", cycle, want);
               chk("done_busy", o_busy, 0);
               chk("done_remaining", o_remaining, 0);
            end
         end
      end
   end

   // One clock edge with the given tick; single-cycle controls drop afterwards.
   task automatic edge_(input logic tk);
      i_tick_1us = tk;
      @(posedge i_clk_36MHz);
      #1;
      i_tick_1us = 1'b0;
      i_start    = 1'b0;
      i_abort    = 1'b0;
   endtask

   task automatic no_tick(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) edge_(1'b0);
   endtask

   // One microsecond: 35 quiet edges, then a tick on the 36th.
   task automatic period();
      no_tick(35);
      edge_(1'b1);
   endtask

   task automatic start(input logic [WIDTH-1:0] d);
      i_start    = 1'b1;
      i_delay_us = d;
   endtask

   initial begin
      // Reset wins over a pending start.
      i_reset = 1'b0;
      start(16'd5);
      edge_(1'b1);
      no_tick(2);
      chk("reset_busy", o_busy, 0);
      chk("reset_done", o_done, 0);
      chk("reset_remaining", o_remaining, 0);
      i_reset = 1'b1;
      edge_(1'b0);

      // Delay of 3 us with a tick every 36 clocks.
      start(16'd3);
      e = cycle + 1;
      exp_q.push_back(e + 108);
      edge_(1'b0);
      chk("a_busy", o_busy, 1);
      chk("a_rem3", o_remaining, 3);
      period();
      chk("a_rem2", o_remaining, 2);
      period();
      chk("a_rem1", o_remaining, 1);
      no_tick(35);
      chk("a_rem1_hold", o_remaining, 1);
      chk("a_busy_hold", o_busy, 1);
      edge_(1'b1);
      chk("a_done", o_done, 1);
      edge_(1'b0);
      chk("a_idle_done", o_done, 0);
      chk("a_idle_busy", o_busy, 0);

      // Zero delay: done on the next cycle, never busy.
      start(16'd0);
      e = cycle + 1;
      exp_q.push_back(e);
      edge_(1'b0);
      chk("z_done", o_done, 1);
      chk("z_busy", o_busy, 0);
      edge_(1'b0);
      chk("z_idle", o_done, 0);

      // Abort in IDLE blocks a start.
      start(16'd6);
      i_abort = 1'b1;
      edge_(1'b0);
      chk("idle_abort_busy", o_busy, 0);
      chk("idle_abort_rem", o_remaining, 0);

      // Abort after 2 ticks, coincident with a tick and a start.
      start(16'd5);
      edge_(1'b0);
      period();
      period();
      chk("c_rem3", o_remaining, 3);
      start(16'd8);
      i_abort = 1'b1;
      edge_(1'b1);
      chk("c_abort_busy", o_busy, 0);
      chk("c_abort_rem", o_remaining, 0);
      chk("c_abort_done", o_done, 0);
      edge_(1'b0);
      start(16'd1);
      e = cycle + 1;
      exp_q.push_back(e + 36);
      edge_(1'b0);
      chk("c_restart_busy", o_busy, 1);
      chk("c_restart_rem", o_remaining, 1);
      period();
      chk("c_restart_done", o_done, 1);
      edge_(1'b0);

      // Start coincident with a tick; second start in RUN ignored.
      start(16'd2);
      e = cycle + 1;
      exp_q.push_back(e + 72);
      edge_(1'b1);
      chk("d_rem_load", o_remaining, 2);
      start(16'd9);
      edge_(1'b0);
      chk("d_ignore_rem", o_remaining, 2);
      chk("d_ignore_busy", o_busy, 1);
      no_tick(34);
      edge_(1'b1);
      chk("d_rem1", o_remaining, 1);
      period();
      chk("d_done", o_done, 1);

      // Back-to-back start in the DONE cycle.
      start(16'd4);
      e = cycle + 1;
      exp_q.push_back(e + 144);
      edge_(1'b0);
      chk("e_busy", o_busy, 1);
      chk("e_rem4", o_remaining, 4);
      chk("e_done_clear", o_done, 0);
      for (int unsigned p = 0; p < 4; p++) period();
      chk("e_done", o_done, 1);
      edge_(1'b0);

      // Reset mid-RUN with 7 remaining.
      start(16'd9);
      edge_(1'b0);
      period();
      period();
      chk("f_rem7", o_remaining, 7);
      i_reset = 1'b0;
      start(16'd3);
      edge_(1'b1);
      chk("f_rst_busy", o_busy, 0);
      chk("f_rst_done", o_done, 0);
      chk("f_rst_rem", o_remaining, 0);
      i_reset = 1'b1;
      edge_(1'b0);
      chk("f_idle_busy", o_busy, 0);

      // First start after reset, tick every cycle.
      start(16'd1);
      e = cycle + 1;
      exp_q.push_back(e + 1);
      edge_(1'b0);
      chk("g_busy", o_busy, 1);
      edge_(1'b1);
      chk("g_done", o_done, 1);
      edge_(1'b0);

      // Maximum count, tick every cycle.
      start('1);
      e = cycle + 1;
      exp_q.push_back(e + 65535);
      edge_(1'b0);
      chk("max_rem", o_remaining, 65535);
      for (int unsigned k = 0; k < 65534; k++) edge_(1'b1);
      chk("max_rem1", o_remaining, 1);
      chk("max_busy", o_busy, 1);
      edge_(1'b1);
      chk("max_done", o_done, 1);
      edge_(1'b1);
      chk("max_no_underflow", o_remaining, 0);

      no_tick(4);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
